axi4lite_master_arbiter: RTL and testbench

AXI4LITE_MASTER_ARBITER -- requirements
Module: axi4lite_master_arbiter

---
 rtl/axi4lite_master_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_axi4lite_master_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_arbiter.sv
// Two-requester AXI4-Lite master with round-robin arbitration.
// Only one AXI transaction is outstanding at a time. The granted requester
// sees a one-cycle accept pulse in the grant cycle. It sees a one-cycle done
// pulse in the cycle after the AXI response, and the response status and read
// data are held until the next completion.
module axi4lite_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,

    input  logic [1:0]                      req_valid,
    input  logic [1:0]                      req_write,
    input  logic [2*ADDR_WIDTH-1:0]         req_addr,
    input  logic [2*DATA_WIDTH-1:0]         req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]     req_wstrb,
    output logic [1:0]                      req_ready,
    output logic [1:0]                      req_done,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [15:0]                     err_count,

    output logic [ADDR_WIDTH-1:0]           axi_awaddr,
    output logic                            axi_awvalid,
    input  logic                            axi_awready,
    output logic [DATA_WIDTH-1:0]           axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         axi_wstrb,
    output logic                            axi_wvalid,
    input  logic                            axi_wready,
    input  logic [1:0]                      axi_bresp,
    input  logic                            axi_bvalid,
    output logic                            axi_bready,
    output logic [ADDR_WIDTH-1:0]           axi_araddr,
    output logic                            axi_arvalid,
    input  logic                            axi_arready,
    input  logic [DATA_WIDTH-1:0]           axi_rdata,
    input  logic [1:0]                      axi_rresp,
    input  logic                            axi_rvalid,
    output logic                            axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   prio_q;      // requester that wins a tie
    logic                   owner_q;     // requester owning the current transaction
    logic                   wr_q;        // current transaction is a write
    logic [ADDR_WIDTH-1:0]  awaddr_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   arvalid_q;
    logic                   bready_q;
    logic                   rready_q;
    logic [1:0]             done_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]             resp_q;
    logic [15:0]            err_q;

    logic                   gnt_d;
    logic                   grant_en;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [DATA_WIDTH-1:0]  wdata_d;
    logic [STRB_WIDTH-1:0]  wstrb_d;
    logic [15:0]            err_d;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   b_hs;
    logic                   r_hs;
    logic                   aw_fin;
    logic                   w_fin;

    // Saturating increment for the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    assign aw_hs  = awvalid_q & axi_awready;
    assign w_hs   = wvalid_q  & axi_wready;
    assign ar_hs  = arvalid_q & axi_arready;
    assign b_hs   = bready_q  & axi_bvalid;
    assign r_hs   = rready_q  & axi_rvalid;
    // A write channel counts as finished if it was already done or handshakes now.
    assign aw_fin = aw_hs | ~awvalid_q;
    assign w_fin  = w_hs  | ~wvalid_q;

    // Round-robin winner and the command fields of that requester.
    always_comb begin
        gnt_d = prio_q;
        if (!req_valid[prio_q]) begin
            gnt_d = ~prio_q;
        end
        addr_d  = gnt_d ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        wdata_d = gnt_d ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        wstrb_d = gnt_d ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
        err_d   = sat_inc16(err_q);
    end

    // The accept pulse is combinational so that it coincides with the grant
    // cycle. It is gated by reset so that it stays low while reset is held.
    assign grant_en  = axi_aresetn & (state_q == IDLE) & (|req_valid);
    assign req_ready = grant_en ? onehot2(gnt_d) : 2'b00;

    // Arbitration, AXI channel sequencing and completion reporting.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            err_q     <= 16'h0000;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        owner_q <= gnt_d;
                        prio_q  <= ~gnt_d;
                        wr_q    <= req_write[gnt_d];
                        if (req_write[gnt_d]) begin
                            awaddr_q  <= addr_d;
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            araddr_q  <= addr_d;
                            arvalid_q <= 1'b1;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        if (aw_hs) begin
                            awvalid_q <= 1'b0;
                        end
                        if (w_hs) begin
                            wvalid_q <= 1'b0;
                        end
                        if (aw_fin && w_fin) begin
                            bready_q <= 1'b1;
                            state_q  <= WAIT_RESP;
                        end
                    end else if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (wr_q && b_hs) begin
                        bready_q <= 1'b0;
                        done_q   <= onehot2(owner_q);
                        resp_q   <= axi_bresp;
                        rdata_q  <= '0;
                        if (axi_bresp != 2'b00) begin
                            err_q <= err_d;
                        end
                        state_q <= IDLE;
                    end else if (!wr_q && r_hs) begin
                        rready_q <= 1'b0;
                        done_q   <= onehot2(owner_q);
                        resp_q   <= axi_rresp;
                        rdata_q  <= axi_rdata;
                        if (axi_rresp != 2'b00) begin
                            err_q <= err_d;
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_done    = done_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign err_count   = err_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Bench for axi4lite_master_arbiter: directed scenarios plus a randomized
// phase, all checked every cycle against a transaction-level model.
module tb_axi4lite_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_write, req_ready, req_done, rsp_resp;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*SW-1:0] req_wstrb;
    logic [DW-1:0]   rsp_rdata;
    logic [15:0]     err_count;
    logic [AW-1:0]   axi_awaddr, axi_araddr;
    logic [DW-1:0]   axi_wdata, axi_rdata;
    logic [SW-1:0]   axi_wstrb;
    logic [1:0]      axi_bresp, axi_rresp;
    logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    axi4lite_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .err_count(err_count),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            m_busy, m_wr, m_aw_p, m_w_p, m_ar_p;
    int            m_owner, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0]    m_done, m_resp;
    int            m_err;
    int            grant_log[$];
    int            done_cnt = 0;

    logic [1:0] e_ready;
    int         e_g;
    bit         e_aw, e_w, e_ar, e_b, e_r;

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_aw_p = 0; m_w_p = 0; m_ar_p = 0;
        m_owner = 0; m_last = 1;   // requester 0 has priority after reset
        m_done = 2'b00; m_resp = 2'b00; m_rdata = '0; m_err = 0;
    endtask

    task automatic model_complete(input logic [1:0] resp, input logic [DW-1:0] data);
        m_done = (m_owner == 1) ? 2'b10 : 2'b01;
        m_resp = resp;
        m_rdata = data;
        if (resp != 2'b00 && m_err < 65535) m_err++;
        m_busy = 0;
        done_cnt++;
    endtask

    initial model_reset();

    // Single compare process: checks outputs each cycle, then advances the model.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_req_done", 64'(req_done), 64'(0));
            chk("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid}), 64'(0));
            chk("rst_readies", 64'({axi_bready, axi_rready}), 64'(0));
            chk("rst_rsp", 64'({rsp_resp, rsp_rdata}), 64'(0));
            chk("rst_err_count", 64'(err_count), 64'(0));
            chk("rst_addr", 64'({axi_awaddr, axi_araddr}), 64'(0));
            chk("rst_wdata", 64'({axi_wstrb, axi_wdata}), 64'(0));
            model_reset();
        end else begin
            e_ready = 2'b00;
            e_g = 0;
            if (!m_busy && req_valid != 2'b00) begin
                if (req_valid == 2'b11) e_g = (m_last == 0) ? 1 : 0;
                else e_g = req_valid[1] ? 1 : 0;
                e_ready = (e_g == 1) ? 2'b10 : 2'b01;
            end
            e_aw = m_busy && m_wr && m_aw_p;
            e_w  = m_busy && m_wr && m_w_p;
            e_ar = m_busy && !m_wr && m_ar_p;
            e_b  = m_busy && m_wr && !m_aw_p && !m_w_p;
            e_r  = m_busy && !m_wr && !m_ar_p;
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("req_done", 64'(req_done), 64'(m_done));
            chk("awvalid", 64'(axi_awvalid), 64'(e_aw));
            chk("wvalid", 64'(axi_wvalid), 64'(e_w));
            chk("arvalid", 64'(axi_arvalid), 64'(e_ar));
            chk("bready", 64'(axi_bready), 64'(e_b));
            chk("rready", 64'(axi_rready), 64'(e_r));
            if (e_aw) chk("awaddr", 64'(axi_awaddr), 64'(m_addr));
            if (e_w) chk("wdata", 64'({axi_wstrb, axi_wdata}), 64'({m_wstrb, m_wdata}));
            if (e_ar) chk("araddr", 64'(axi_araddr), 64'(m_addr));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(m_resp));
            chk("err_count", 64'(err_count), 64'(m_err));

            m_done = 2'b00;
            if (!m_busy) begin
                if (e_ready != 2'b00) begin
                    grant_log.push_back(e_g);
                    m_busy = 1; m_owner = e_g; m_last = e_g;
                    m_wr = req_write[e_g];
                    m_addr = req_addr[e_g*AW +: AW];
                    m_wdata = req_wdata[e_g*DW +: DW];
                    m_wstrb = req_wstrb[e_g*SW +: SW];
                    m_aw_p = m_wr; m_w_p = m_wr; m_ar_p = !m_wr;
                end
            end else begin
                if (e_b && axi_bvalid) model_complete(axi_bresp, '0);
                else if (e_r && axi_rvalid) model_complete(axi_rresp, axi_rdata);
                if (e_aw && axi_awready) m_aw_p = 0;
                if (e_w && axi_wready) m_w_p = 0;
                if (e_ar && axi_arready) m_ar_p = 0;
            end
        end
    end

    // ---------------- AXI slave: 0 zero-wait, 1 random, 2 manual readies ----------------
    int            smode = 0;
    bit            s_hold = 0;
    logic [1:0]    s_resp_cfg = 2'b00;
    logic [DW-1:0] s_rdata_cfg = '0;
    bit s_aw_seen, s_w_seen, s_b_owed, s_r_owed, s_b_taken, s_r_taken;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            s_aw_seen = 0; s_w_seen = 0; s_b_owed = 0; s_r_owed = 0;
            s_b_taken = 0; s_r_taken = 0;
            axi_bvalid = 0; axi_rvalid = 0; axi_bresp = 0; axi_rresp = 0; axi_rdata = '0;
        end else begin
            if (s_b_taken) begin axi_bvalid = 0; s_b_taken = 0; end
            if (s_r_taken) begin axi_rvalid = 0; s_r_taken = 0; end
            if (smode == 0) begin
                axi_awready = 1; axi_wready = 1; axi_arready = 1;
            end else if (smode == 1) begin
                axi_awready = 1'($urandom_range(1, 0));
                axi_wready  = 1'($urandom_range(1, 0));
                axi_arready = 1'($urandom_range(1, 0));
            end
            if (!axi_bvalid && s_b_owed && !s_hold && (smode != 1 || $urandom_range(2, 0) == 0)) begin
                axi_bvalid = 1;
                axi_bresp = (smode == 1) ? 2'($urandom_range(3, 0)) : s_resp_cfg;
                s_b_owed = 0;
            end
            if (!axi_rvalid && s_r_owed && !s_hold && (smode != 1 || $urandom_range(2, 0) == 0)) begin
                axi_rvalid = 1;
                axi_rresp = (smode == 1) ? 2'($urandom_range(3, 0)) : s_resp_cfg;
                axi_rdata = (smode == 1) ? DW'($urandom) : s_rdata_cfg;
                s_r_owed = 0;
            end
        end
        #2;
        if (rst_n) begin
            if (axi_awvalid && axi_awready) s_aw_seen = 1;
            if (axi_wvalid && axi_wready) s_w_seen = 1;
            if (s_aw_seen && s_w_seen) begin s_b_owed = 1; s_aw_seen = 0; s_w_seen = 0; end
            if (axi_arvalid && axi_arready) s_r_owed = 1;
            if (axi_bvalid && axi_bready) s_b_taken = 1;
            if (axi_rvalid && axi_rready) s_r_taken = 1;
        end
    end

    // ---------------- random requesters (active when rmode == 1) ----------------
    int rmode = 0;
    bit r_pend[2];

    always begin
        @(negedge clk);
        if (rmode == 1) begin
            for (int i = 0; i < 2; i++) begin
                if (!r_pend[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        r_pend[i] = 1;
                        req_valid[i] = 1;
                        req_write[i] = 1'($urandom_range(1, 0));
                        req_addr[i*AW +: AW] = AW'($urandom) & ~AW'(3);
                        req_wdata[i*DW +: DW] = DW'($urandom);
                        req_wstrb[i*SW +: SW] = SW'($urandom_range(15, 0));
                    end else begin
                        req_valid[i] = 0;
                    end
                end
            end
            #2;
            for (int i = 0; i < 2; i++) if (req_ready[i]) r_pend[i] = 0;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(); #3; rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic wait_grant(input int idx);
        int n = 0;
        while (!req_ready[idx] && n < 100) begin tick(); #2; n++; end
        chk("grant_in_time", 64'(n < 100), 64'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 500) begin tick(); #2; n++; end
        chk("idle_in_time", 64'(n < 500), 64'(1));
        tick(); #2;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = '1;
    endtask

    task automatic err_write();
        tick(); set_req(1, 1, 32'h60, 32'h1); req_valid = 2'b10; #2;
        wait_grant(1);
        tick(); req_valid = 2'b00;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    int base;
    int done_before;

    initial begin
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_bvalid = 0; axi_rvalid = 0; axi_bresp = 0; axi_rresp = 0; axi_rdata = '0;
        repeat (3) tick();

        // Zero-wait read from requester 0.
        tick(); rst_n = 1;
        s_rdata_cfg = 32'hDEADBEEF;
        set_req(0, 0, 32'h10, 32'h0); req_valid = 2'b01; #2;
        chk("rd_ready_T", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b00; #2;
        chk("rd_arvalid_T1", 64'(axi_arvalid), 64'h1);
        chk("rd_araddr_T1", 64'(axi_araddr), 64'h10);
        tick(); #2;
        chk("rd_done_T2", 64'(req_done), 64'h0);
        tick(); #2;
        chk("rd_done_T3", 64'(req_done), 64'h1);
        chk("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd_resp", 64'(rsp_resp), 64'h0);

        // Both requesters continuously valid after reset.
        do_reset();
        set_req(0, 0, 32'h100, 32'h0); set_req(1, 0, 32'h200, 32'h0);
        req_valid = 2'b11;
        base = grant_log.size();
        repeat (12) tick();
        req_valid = 2'b00;
        wait_idle();
        chk("rr_grant_count", 64'(grant_log.size() - base), 64'd4);
        chk("rr_g0", 64'(grant_log[base]), 64'd0);
        chk("rr_g1", 64'(grant_log[base+1]), 64'd1);
        chk("rr_g2", 64'(grant_log[base+2]), 64'd0);
        chk("rr_g3", 64'(grant_log[base+3]), 64'd1);

        // Write with AW accepted at T+1 and W accepted at T+4.
        smode = 2; axi_awready = 0; axi_wready = 0; axi_arready = 0;
        tick();
        set_req(0, 1, 32'h20, 32'h12345678); req_valid = 2'b01; #2;
        chk("wr_ready_T", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b00; axi_awready = 1; #2;
        chk("wr_valids_T1", 64'({axi_awvalid, axi_wvalid}), 64'h3);
        tick(); axi_awready = 0; #2;
        chk("wr_valids_T2", 64'({axi_awvalid, axi_wvalid, axi_bready}), 64'h2);
        tick(); #2;
        chk("wr_wvalid_T3", 64'(axi_wvalid), 64'h1);
        tick(); axi_wready = 1; #2;
        chk("wr_T4", 64'({axi_wvalid, axi_bready}), 64'h2);
        chk("wr_wdata_T4", 64'(axi_wdata), 64'h12345678);
        tick(); axi_wready = 0; #2;
        chk("wr_bready_T5", 64'({axi_wvalid, axi_bready}), 64'h1);
        tick(); #2;
        chk("wr_done_T6", 64'(req_done), 64'h1);
        smode = 0;
        tick();

        // Error responses and counter saturation.
        s_resp_cfg = 2'b10;
        repeat (3) err_write();
        chk("err_three", 64'(err_count), 64'd3);
        tick(); #2;
        force dut.err_q = 16'hFFFE;
        m_err = 65534;
        #1;
        release dut.err_q;
        err_write();
        chk("err_sat_hit", 64'(err_count), 64'hFFFF);
        err_write();
        chk("err_sat_hold", 64'(err_count), 64'hFFFF);
        s_resp_cfg = 2'b00;

        // Reset while waiting for a read response.
        s_hold = 1;
        tick(); set_req(0, 0, 32'h80, 32'h0); req_valid = 2'b01; #2;
        chk("rst_test_grant", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b00;
        tick(); #2;
        chk("rst_test_rready", 64'(axi_rready), 64'h1);
        #1; rst_n = 0; #1;
        chk("async_rst_outs", 64'({axi_rready, axi_arvalid, axi_bready, req_ready, req_done}), 64'h0);
        chk("async_rst_err", 64'(err_count), 64'h0);
        tick(); tick();
        rst_n = 1; s_hold = 0;
        set_req(0, 1, 32'h90, 32'hA5A5A5A5); set_req(1, 1, 32'h94, 32'h5A5A5A5A);
        req_valid = 2'b11; #2;
        chk("post_rst_winner", 64'(req_ready), 64'h1);
        tick(); req_valid = 2'b10; #2;
        wait_grant(1);
        tick(); req_valid = 2'b00;
        wait_idle();

        // AR held off for 50 cycles while requester 1 toggles.
        smode = 2; axi_awready = 0; axi_wready = 0; axi_arready = 0;
        tick(); set_req(0, 0, 32'h44, 32'h0); set_req(1, 1, 32'h48, 32'h7); req_valid = 2'b01; #2;
        chk("stall_grant", 64'(req_ready), 64'h1);
        for (int k = 0; k < 50; k++) begin
            tick(); req_valid = (k % 2 == 0) ? 2'b10 : 2'b00; #2;
            chk("stall_ar", 64'({axi_arvalid, axi_araddr}), {31'd0, 1'b1, 32'h44});
            chk("stall_no_grant", 64'(req_ready), 64'h0);
        end
        tick(); req_valid = 2'b00; axi_arready = 1; #2;
        chk("stall_release", 64'(axi_arvalid), 64'h1);
        tick(); axi_arready = 0;
        wait_idle();
        smode = 0;

        // Randomized traffic against the model.
        done_before = done_cnt;
        r_pend[0] = 0; r_pend[1] = 0;
        smode = 1; rmode = 1;
        repeat (3000) tick();
        rmode = 0;
        tick(); req_valid = 2'b00; smode = 0;
        wait_idle();
        chk("random_activity", 64'(done_cnt - done_before > 100), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
